alu_cond_writeback: RTL and testbench

Downstream stage of the 5-bit shift/ALU datapath. Accepts each ALU Result and its ALUFlags through a valid/ready handshake and evaluates an ARM-style condition code against the architectural NZCV register. If the condition passes, it writes Result into a small register file and optionally updates NZCV. The register file's two combinational read ports supply the a/b operands back to the shift/ALU stage.

---
 rtl/alu_cond_writeback.sv | 145 ++++++++++++++
 tb/tb_alu_cond_writeback.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cond_writeback.sv
// Conditional write-back stage for the shift/ALU datapath.
// Each op goes through three states. In IDLE the op is accepted. In EVAL the
// condition is checked against the architectural NZCV. In COMMIT the op is
// either written back or discarded. The two register-file read ports feed
// operands back upstream with no bypass.
module alu_cond_writeback #(
    parameter int WIDTH = 5,
    parameter int NREGS = 4,
    parameter int CNTW  = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Result,
    input  logic [3:0]       ALUFlags,
    input  logic [3:0]       cond,
    input  logic             setflags,
    input  logic [AW-1:0]    rd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic [3:0]       Flags,
    output logic             wb_done,
    output logic             wb_skip,
    output logic [CNTW-1:0]  retired,
    output logic [CNTW-1:0]  skipped
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] res_q;
    logic [3:0]       aluflags_q;
    logic [3:0]       cond_q;
    logic             setflags_q;
    logic [AW-1:0]    rd_q;
    logic             cond_ex;

    // ARM condition evaluation; flags are packed {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = cf;
            4'h3:    cond_pass = !cf;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = cf && !z;
            4'h9:    cond_pass = !cf || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            default: cond_pass = 1'b1;  // AL, and 0xF is also treated as always
        endcase
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] x);
        sat_inc = (x == {CNTW{1'b1}}) ? x : x + 1'b1;
    endfunction

    // Combinational read ports; a commit shows up once the commit edge has passed.
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    // Handshake FSM with the op latch, condition register, register file, flags,
    // pulses and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            res_q      <= '0;
            aluflags_q <= '0;
            cond_q     <= '0;
            setflags_q <= 1'b0;
            rd_q       <= '0;
            cond_ex    <= 1'b0;
            Flags      <= '0;
            wb_done    <= 1'b0;
            wb_skip    <= 1'b0;
            retired    <= '0;
            skipped    <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wb_done <= 1'b0;
            wb_skip <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        res_q      <= Result;
                        aluflags_q <= ALUFlags;
                        cond_q     <= cond;
                        setflags_q <= setflags;
                        rd_q       <= rd;
                        in_ready   <= 1'b0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    // The condition uses architectural flags, which include the previous commit.
                    cond_ex <= cond_pass(cond_q, Flags);
                    state   <= COMMIT;
                end
                COMMIT: begin
                    if (cond_ex) begin
                        regs[rd_q] <= res_q;
                        if (setflags_q) begin
                            Flags <= aluflags_q;
                        end
                        wb_done <= 1'b1;
                        retired <= sat_inc(retired);
                    end else begin
                        wb_skip <= 1'b1;
                        skipped <= sat_inc(skipped);
                    end
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cond_writeback.sv
// Directed bench for alu_cond_writeback: table of ops plus hand-written
// sequences for throughput, mid-op reset and counter saturation.
module tb_alu_cond_writeback;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] Result = '0;
    logic [3:0] ALUFlags = '0;
    logic [3:0] cond = '0;
    logic       setflags = 1'b0;
    logic [1:0] rd = '0;
    logic [1:0] ra1 = '0;
    logic [1:0] ra2 = '0;
    logic [4:0] rd1;
    logic [4:0] rd2;
    logic [3:0] Flags;
    logic       wb_done;
    logic       wb_skip;
    logic [7:0] retired;
    logic [7:0] skipped;

    int total = 0;
    int bad = 0;
    int exp_ret = 0;
    int exp_skp = 0;

    alu_cond_writeback #(.WIDTH(5), .NREGS(4), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Result(Result), .ALUFlags(ALUFlags), .cond(cond), .setflags(setflags),
        .rd(rd), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .Flags(Flags),
        .wb_done(wb_done), .wb_skip(wb_skip), .retired(retired), .skipped(skipped)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] res;
        logic [3:0] af;
        logic [3:0] c;
        logic       sf;
        logic [1:0] d;
        logic       pass;
        logic [3:0] flg;
        logic [4:0] regv;
    } vec_t;

    vec_t vec [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One op through the handshake, with latency, pulse, write-back and counter checks.
    task automatic do_op(input logic [4:0] r, input logic [3:0] af, input logic [3:0] c,
                         input logic sf, input logic [1:0] d, input logic pass,
                         input logic [3:0] flg, input logic [4:0] regv);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        Result = r; ALUFlags = af; cond = c; setflags = sf; rd = d;
        ra1 = d; ra2 = d; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("pulse_t1", {wb_done, wb_skip}, 2'b00);
        @(posedge clk); @(negedge clk);
        check("pulse_t2", {wb_done, wb_skip}, 2'b00);
        @(posedge clk); @(negedge clk);
        if (pass) exp_ret = (exp_ret == 255) ? 255 : exp_ret + 1;
        else      exp_skp = (exp_skp == 255) ? 255 : exp_skp + 1;
        check("wb_done", 32'(wb_done), 32'(pass));
        check("wb_skip", 32'(wb_skip), 32'(!pass));
        check("flags", 32'(Flags), 32'(flg));
        check("rd1", 32'(rd1), 32'(regv));
        check("rd2", 32'(rd2), 32'(regv));
        check("retired", 32'(retired), 32'(exp_ret));
        check("skipped", 32'(skipped), 32'(exp_skp));
        @(posedge clk); @(negedge clk);
        check("pulse_clear", {wb_done, wb_skip}, 2'b00);
    endtask

    initial begin
        vec[0]  = '{5'h13, 4'b0000, 4'hE, 1'b0, 2'd2, 1'b1, 4'b0000, 5'h13};
        vec[1]  = '{5'h00, 4'b0100, 4'hE, 1'b1, 2'd0, 1'b1, 4'b0100, 5'h00};
        vec[2]  = '{5'h1F, 4'b0000, 4'h0, 1'b0, 2'd1, 1'b1, 4'b0100, 5'h1F};
        vec[3]  = '{5'h0A, 4'b1000, 4'h1, 1'b1, 2'd3, 1'b0, 4'b0100, 5'h00};
        vec[4]  = '{5'h05, 4'b1000, 4'hE, 1'b1, 2'd3, 1'b1, 4'b1000, 5'h05};
        vec[5]  = '{5'h06, 4'b0000, 4'hB, 1'b0, 2'd2, 1'b1, 4'b1000, 5'h06};
        vec[6]  = '{5'h07, 4'b0000, 4'hA, 1'b0, 2'd2, 1'b0, 4'b1000, 5'h06};
        vec[7]  = '{5'h08, 4'b1001, 4'hE, 1'b1, 2'd0, 1'b1, 4'b1001, 5'h08};
        vec[8]  = '{5'h09, 4'b0000, 4'hC, 1'b0, 2'd1, 1'b1, 4'b1001, 5'h09};
        vec[9]  = '{5'h11, 4'b0010, 4'hD, 1'b1, 2'd1, 1'b0, 4'b1001, 5'h09};
        vec[10] = '{5'h12, 4'b0110, 4'h8, 1'b1, 2'd2, 1'b0, 4'b1001, 5'h06};
        vec[11] = '{5'h12, 4'b0110, 4'h9, 1'b1, 2'd2, 1'b1, 4'b0110, 5'h12};
        vec[12] = '{5'h14, 4'b0000, 4'h8, 1'b0, 2'd3, 1'b0, 4'b0110, 5'h05};
        vec[13] = '{5'h15, 4'b0001, 4'h2, 1'b1, 2'd3, 1'b1, 4'b0001, 5'h15};
        vec[14] = '{5'h16, 4'b0000, 4'h6, 1'b0, 2'd0, 1'b1, 4'b0001, 5'h16};
        vec[15] = '{5'h17, 4'b0000, 4'h7, 1'b0, 2'd0, 1'b0, 4'b0001, 5'h16};
        vec[16] = '{5'h18, 4'b0000, 4'h4, 1'b0, 2'd1, 1'b0, 4'b0001, 5'h09};
        vec[17] = '{5'h18, 4'b0000, 4'h5, 1'b0, 2'd1, 1'b1, 4'b0001, 5'h18};
        vec[18] = '{5'h19, 4'b1111, 4'h3, 1'b1, 2'd2, 1'b1, 4'b1111, 5'h19};
        vec[19] = '{5'h1A, 4'b0000, 4'hF, 1'b0, 2'd3, 1'b1, 4'b1111, 5'h1A};

        // Reset state
        #12;
        check("rst_flags", 32'(Flags), 32'd0);
        check("rst_pulses", {wb_done, wb_skip}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_counts", {retired, skipped}, 16'd0);
        for (int a = 0; a < 4; a++) begin
            ra1 = 2'(a);
            #1;
            check("rst_reg", 32'(rd1), 32'd0);
        end

        // Table-driven ops
        for (int i = 0; i < 20; i++) begin
            do_op(vec[i].res, vec[i].af, vec[i].c, vec[i].sf, vec[i].d,
                  vec[i].pass, vec[i].flg, vec[i].regv);
        end

        // in_valid held high across three ops: one accept every three cycles
        @(negedge clk);
        in_valid = 1'b1; Result = 5'h01; ALUFlags = 4'b0000; cond = 4'hE; setflags = 1'b0; rd = 2'd0;
        for (int k = 0; k < 3; k++) begin
            check("thr_ready_hi", 32'(in_ready), 32'd1);
            @(posedge clk); @(negedge clk);
            if (k == 2) in_valid = 1'b0;
            else begin
                Result = 5'(k + 2);
                rd = 2'(k + 1);
            end
            check("thr_ready_lo1", 32'(in_ready), 32'd0);
            @(posedge clk); @(negedge clk);
            check("thr_ready_lo2", 32'(in_ready), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        exp_ret += 3;
        check("thr_retired", 32'(retired), 32'(exp_ret));
        for (int a = 0; a < 3; a++) begin
            ra1 = 2'(a);
            #1;
            check("thr_reg", 32'(rd1), 32'(a + 1));
        end
        ra1 = 2'd3;
        #1;
        check("thr_reg3", 32'(rd1), 32'h1A);

        // Reset asserted while the op sits in EVAL
        @(negedge clk);
        Result = 5'h1F; ALUFlags = 4'b0000; cond = 4'hE; setflags = 1'b1; rd = 2'd1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_flags", 32'(Flags), 32'd0);
        check("mid_counts", {retired, skipped}, 16'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("mid_pulse", {wb_done, wb_skip}, 2'b00);
        end
        for (int a = 0; a < 4; a++) begin
            ra1 = 2'(a);
            #1;
            check("mid_reg", 32'(rd1), 32'd0);
        end
        rst_n = 1'b1;
        exp_ret = 0;
        exp_skp = 0;
        @(negedge clk);
        check("mid_ready", 32'(in_ready), 32'd1);
        do_op(5'h0A, 4'b0101, 4'hE, 1'b1, 2'd1, 1'b1, 4'b0101, 5'h0A);

        // Counter saturation with 256 AL ops
        for (int i = 0; i < 256; i++) begin
            do_op(5'(i), 4'b0000, 4'hE, 1'b0, 2'(i), 1'b1, 4'b0101, 5'(i));
        end
        check("sat_retired", 32'(retired), 32'd255);
        check("sat_skipped", 32'(skipped), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
